// File: rtl/rsa_mont_setup_pkg.sv
// Shared RSA definitions: setup FSM state encoding and default operand width.
package rsa_mont_setup_pkg;

  localparam int DEFAULT_WIDTH = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INV  = 2'd1,
    R2   = 2'd2,
    FIN  = 2'd3
  } state_t;

endpackage

// File: rtl/rsa_mod_double.sv
// Combinational modular doubling: r -> 2r mod n, for r already in [0, n-1].
module rsa_mod_double
  import rsa_mont_setup_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] r,
  input  logic [WIDTH-1:0] n,
  output logic [WIDTH-1:0] r_dbl
);

  logic [WIDTH:0] dbl;
  logic [WIDTH:0] diff;

  // 2r < 2n, so a single conditional subtract brings the result back into range
  assign dbl  = {r, 1'b0};
  assign diff = dbl - {1'b0, n};

  always_comb begin
    r_dbl = dbl[WIDTH-1:0];
    if (dbl >= {1'b0, n}) r_dbl = diff[WIDTH-1:0];
  end

endmodule

// File: rtl/rsa_mont_setup.sv
// Montgomery setup: computes -N^-1 mod 2^WIDTH and 2^(2*WIDTH) mod N with
// shift/add only, for hand-off to the rsa core.
//
// state | meaning
// IDLE  | waiting for start; outputs hold the last result
// INV   | Hensel lifting of N^-1, one bit per cycle (bits 1..WIDTH-1)
// R2    | 2*WIDTH modular doublings of r
// FIN   | done pulse; results and err valid
module rsa_mont_setup
  import rsa_mont_setup_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] N,
  output logic [WIDTH-1:0] N_INV,
  output logic [WIDTH-1:0] R2_MOD_N,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int CW = $clog2(2 * WIDTH);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t           state;
  logic [WIDTH-1:0] n_q;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] p;
  logic [WIDTH-1:0] r;
  logic [WIDTH-1:0] r_dbl;
  logic [CW-1:0]    cnt;

  rsa_mod_double #(.WIDTH(WIDTH)) u_mod_double (
    .r     (r),
    .n     (n_q),
    .r_dbl (r_dbl)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      n_q      <= '0;
      x        <= '0;
      p        <= '0;
      r        <= '0;
      cnt      <= '0;
      N_INV    <= '0;
      R2_MOD_N <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            n_q  <= N;
            x    <= ONE;
            p    <= N;
            // r starts at 1 mod N so that N=1 yields 0
            r    <= (N == ONE) ? '0 : ONE;
            cnt  <= CW'(1);
            busy <= 1'b1;
            err  <= 1'b0;
            if (N[0]) begin
              state <= INV;
            end else begin
              state    <= FIN;
              err      <= 1'b1;
              N_INV    <= '0;
              R2_MOD_N <= '0;
              done     <= 1'b1;
            end
          end
        end
        INV: begin
          if (p[cnt]) begin
            x <= x + (ONE << cnt);
            p <= p + (n_q << cnt);
          end
          if (cnt == CW'(WIDTH - 1)) begin
            state <= R2;
            cnt   <= CW'(2 * WIDTH - 1);
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        R2: begin
          r <= r_dbl;
          if (cnt == '0) begin
            state    <= FIN;
            done     <= 1'b1;
            N_INV    <= ~x + ONE;
            R2_MOD_N <= r_dbl;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        FIN: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rsa_mont_setup.sv
// Directed self-checking bench for rsa_mont_setup at WIDTH=64.
module tb_rsa_mont_setup;

  localparam int W = 64;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] n;
  logic [W-1:0] n_inv;
  logic [W-1:0] r2;
  logic         busy;
  logic         done;
  logic         err;

  int checks = 0;
  int errors = 0;

  rsa_mont_setup #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .N        (n),
    .N_INV    (n_inv),
    .R2_MOD_N (r2),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  task automatic apply_start(input logic [W-1:0] nv);
    @(negedge clk);
    n     = nv;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // cycles counted from the edge that sampled start; -1 on timeout
  task automatic wait_done(output int cyc);
    cyc = 0;
    while (cyc < 1000) begin
      @(negedge clk);
      cyc++;
      if (done) return;
    end
    cyc = -1;
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b0;
    n     = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (n_inv !== '0 || r2 !== '0) begin
      errors++;
      $display("FAIL reset_data: n_inv=%h r2=%h expected 0/0", n_inv, r2);
    end
    checks++;
    if ({busy, done, err} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags: busy/done/err=%b expected 000", {busy, done, err});
    end
    rst = 1'b0;
  endtask

  task automatic test_odd_vectors();
    logic [W-1:0] tn  [4];
    logic [W-1:0] tinv[4];
    logic [W-1:0] tr2 [4];
    int cyc;
    tn[0] = 64'd11;                 tinv[0] = 64'hD1745D1745D1745D; tr2[0] = 64'd3;
    tn[1] = 64'd17;                 tinv[1] = 64'h0F0F0F0F0F0F0F0F; tr2[1] = 64'd1;
    tn[2] = 64'hFFFFFFFFFFFFFFFF;   tinv[2] = 64'd1;                tr2[2] = 64'd1;
    tn[3] = 64'd1;                  tinv[3] = 64'hFFFFFFFFFFFFFFFF; tr2[3] = 64'd0;
    for (int k = 0; k < 4; k++) begin
      apply_start(tn[k]);
      n = ~tn[k];
      wait_done(cyc);
      checks++;
      if (cyc !== 192) begin
        errors++;
        $display("FAIL odd_latency N=%h: done at cycle %0d expected 192", tn[k], cyc);
      end
      checks++;
      if (n_inv !== tinv[k]) begin
        errors++;
        $display("FAIL odd_n_inv N=%h: got %h expected %h", tn[k], n_inv, tinv[k]);
      end
      checks++;
      if (r2 !== tr2[k]) begin
        errors++;
        $display("FAIL odd_r2 N=%h: got %h expected %h", tn[k], r2, tr2[k]);
      end
      checks++;
      if (err !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL odd_flags N=%h: err=%b busy=%b expected 0/1", tn[k], err, busy);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || n_inv !== tinv[k] || r2 !== tr2[k]) begin
        errors++;
        $display("FAIL odd_after N=%h: done=%b busy=%b n_inv=%h r2=%h expected 0/0/%h/%h",
                 tn[k], done, busy, n_inv, r2, tinv[k], tr2[k]);
      end
    end
  endtask

  task automatic test_even();
    int cyc;
    apply_start(64'd10);
    wait_done(cyc);
    checks++;
    if (cyc !== 1) begin
      errors++;
      $display("FAIL even_latency: done at cycle %0d expected 1", cyc);
    end
    checks++;
    if (err !== 1'b1 || n_inv !== '0 || r2 !== '0) begin
      errors++;
      $display("FAIL even_result: err=%b n_inv=%h r2=%h expected 1/0/0", err, n_inv, r2);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (err !== 1'b1 || done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL even_hold: err=%b done=%b busy=%b expected 1/0/0", err, done, busy);
    end
  endtask

  task automatic test_busy_ignore();
    int  cyc;
    bit  got;
    apply_start(64'd11);
    cyc = 0;
    got = 1'b0;
    while (cyc < 1000 && !got) begin
      @(negedge clk);
      cyc++;
      if (cyc == 10) begin
        checks++;
        if (err !== 1'b0 || busy !== 1'b1 || n_inv !== '0) begin
          errors++;
          $display("FAIL busy_midrun: err=%b busy=%b n_inv=%h expected 0/1/0", err, busy, n_inv);
        end
      end
      if (cyc == 50) begin
        n     = 64'd17;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
      end
      if (done) got = 1'b1;
    end
    checks++;
    if (!got || cyc !== 192) begin
      errors++;
      $display("FAIL busy_latency: done at cycle %0d expected 192", got ? cyc : -1);
    end
    checks++;
    if (n_inv !== 64'hD1745D1745D1745D || r2 !== 64'd3) begin
      errors++;
      $display("FAIL busy_result: n_inv=%h r2=%h expected D1745D1745D1745D/3", n_inv, r2);
    end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL busy_no_rerun: busy=%b done=%b expected 0/0", busy, done);
    end
  endtask

  task automatic test_mid_reset();
    int cyc;
    bit seen;
    apply_start(64'd11);
    seen = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (seen || {busy, done, err} !== 3'b000 || n_inv !== '0 || r2 !== '0) begin
      errors++;
      $display("FAIL midreset_clear: seen_done=%b busy/done/err=%b n_inv=%h r2=%h expected 0/000/0/0",
               seen, {busy, done, err}, n_inv, r2);
    end
    rst   = 1'b0;
    n     = 64'd17;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(cyc);
    checks++;
    if (cyc !== 192) begin
      errors++;
      $display("FAIL midreset_latency: done at cycle %0d expected 192", cyc);
    end
    checks++;
    if (n_inv !== 64'h0F0F0F0F0F0F0F0F || r2 !== 64'd1 || err !== 1'b0) begin
      errors++;
      $display("FAIL midreset_result: n_inv=%h r2=%h err=%b expected 0F0F0F0F0F0F0F0F/1/0",
               n_inv, r2, err);
    end
  endtask

  initial begin
    test_reset();
    test_odd_vectors();
    test_even();
    test_busy_ignore();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
